// File: rtl/uart_pkt_pkg.sv
// uart_pkt_pkg
// Shared types and the CRC-8 step function for the host-link packet receiver.
//   pkt_state_t : frame parser states
//   rx_state_t  : UART byte receiver states
//   CRC8_POLY   : CRC-8 polynomial (x^8 + x^2 + x + 1)
//   crc8_next   : advances a CRC-8 (MSB first) by one byte
package uart_pkt_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      LEN,
      DATA,
      CRC,
      DRAIN
   } pkt_state_t;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_t;

   localparam logic [7:0] CRC8_POLY = 8'h07;

   function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic [7:0] data);
      logic [7:0] c;
      c = crc ^ data;
      for (int i = 0; i < 8; i++) begin
         c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
      end
      return c;
   endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte
// 8N1 UART byte receiver with a 2-flop input synchroniser.
//   state    | meaning
//   RX_IDLE  | waiting for a falling edge on the synchronised line
//   RX_START | timing to mid start bit; line high there means a glitch
//   RX_DATA  | sampling 8 data bits, LSB first, one per DIV cycles
//   RX_STOP  | sampling the stop bit
// Ports:
//   clk_100    : system clock
//   rst        : asynchronous active-high reset
//   rx         : UART line, idle high
//   rx_byte    : last assembled byte, valid while byte_valid is high
//   byte_valid : 1-cycle pulse in the cycle a good stop bit is sampled
//   frame_err  : 1-cycle pulse in the cycle a low stop bit is sampled
// DIV (clock cycles per bit) must be at least 8.
module uart_rx_byte
   import uart_pkt_pkg::*;
#(
   parameter int DIV = 868
) (
   input  logic       clk_100,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] rx_byte,
   output logic       byte_valid,
   output logic       frame_err
);

   localparam int              CNT_W = $clog2(DIV);
   localparam logic [CNT_W-1:0] HALF  = CNT_W'(DIV / 2 - 1);
   localparam logic [CNT_W-1:0] FULL  = CNT_W'(DIV - 1);

   logic             rx_meta, rx_sync, rx_prev;
   rx_state_t        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shift_q, shift_d;

   always_ff @(posedge clk_100 or posedge rst) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
         rx_prev <= 1'b1;
         state_q <= RX_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
      end else begin
         rx_meta <= rx;
         rx_sync <= rx_meta;
         rx_prev <= rx_sync;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      bit_d      = bit_q;
      shift_d    = shift_q;
      byte_valid = 1'b0;
      frame_err  = 1'b0;
      case (state_q)
         RX_IDLE: begin
            if (rx_prev && !rx_sync) begin
               cnt_d   = HALF;
               state_d = RX_START;
            end
         end
         RX_START: begin
            if (cnt_q == '0) begin
               if (rx_sync) begin
                  state_d = RX_IDLE;
               end else begin
                  cnt_d   = FULL;
                  bit_d   = '0;
                  state_d = RX_DATA;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         RX_DATA: begin
            if (cnt_q == '0) begin
               shift_d = {rx_sync, shift_q[7:1]};
               cnt_d   = FULL;
               if (bit_q == 3'd7) begin
                  state_d = RX_STOP;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         RX_STOP: begin
            if (cnt_q == '0) begin
               byte_valid = rx_sync;
               frame_err  = !rx_sync;
               state_d    = RX_IDLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: state_d = RX_IDLE;
      endcase
   end

   assign rx_byte = shift_q;

endmodule

// File: rtl/uart_pkt_rx.sv
// uart_pkt_rx
// UART packet receiver/deframer: PREFIX, ADDR, LEN, PAYLOAD[LEN], CRC.
// The payload is buffered and only streamed out once the frame checks good.
//   state | meaning
//   IDLE  | hunting for PREFIX; everything else is ignored
//   ADDR  | next byte is the destination address
//   LEN   | next byte is the payload length
//   DATA  | storing payload bytes into the buffer
//   CRC   | next byte is compared against the running CRC-8
//   DRAIN | streaming the buffered payload on the m_* interface
// Ports:
//   clk_100, rst           : system clock, asynchronous active-high reset
//   rx                     : UART line, idle high
//   m_data/m_valid/m_ready : payload stream, beat on m_valid && m_ready
//   m_first, m_last        : first / last beat of the frame
//   m_addr                 : frame address, held through the drain
//   pkt_done               : 1-cycle pulse after a good frame is delivered
//   err_*                  : 1-cycle error pulses, at most one per cycle
module uart_pkt_rx
   import uart_pkt_pkg::*;
#(
   parameter int         SYS_CLK_HZ   = 100000000,
   parameter int         BAUDRATE     = 115200,
   parameter logic [7:0] PREFIX       = 8'hDD,
   parameter int         ADDR_W       = 7,
   parameter int         MAX_LEN      = 64,
   parameter int         CRC_MODE     = 1,
   parameter int         TIMEOUT_BITS = 20
) (
   input  logic              clk_100,
   input  logic              rst,
   input  logic              rx,
   output logic [7:0]        m_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              m_first,
   output logic              m_last,
   output logic [ADDR_W-1:0] m_addr,
   output logic              pkt_done,
   output logic              err_crc,
   output logic              err_len,
   output logic              err_timeout,
   output logic              err_frame,
   output logic              err_overrun
);

   localparam int              DIV       = SYS_CLK_HZ / BAUDRATE;
   localparam int              TO_CYC    = TIMEOUT_BITS * DIV;
   localparam int              TO_W      = $clog2(TO_CYC + 1);
   localparam logic [TO_W-1:0] TO_LOAD   = TO_W'(TO_CYC - 1);
   localparam int              AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam logic [8:0]      MAX_LEN_V = 9'(MAX_LEN);

   logic [7:0]        rx_byte;
   logic              byte_valid, frame_err;

   pkt_state_t        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        len_q, len_d;
   logic [7:0]        idx_q, idx_d, idx_inc;
   logic [7:0]        crc_q, crc_d;
   logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
   logic              wr_en;
   logic              done_d, crc_err_d, len_err_d, to_err_d, frm_err_d, ovr_err_d;

   logic [7:0]        mem [MAX_LEN];

   uart_rx_byte #(
      .DIV(DIV)
   ) u_rx (
      .clk_100    (clk_100),
      .rst        (rst),
      .rx         (rx),
      .rx_byte    (rx_byte),
      .byte_valid (byte_valid),
      .frame_err  (frame_err)
   );

   // idx is the write pointer while filling and is reused as the read pointer
   // while draining; the buffer is never written and read in the same frame phase.
   assign idx_inc = idx_q + 8'd1;

   always_ff @(posedge clk_100) begin
      if (wr_en) begin
         mem[idx_q[AW-1:0]] <= rx_byte;
      end
   end

   always_ff @(posedge clk_100 or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         len_q       <= '0;
         idx_q       <= '0;
         crc_q       <= '0;
         to_cnt_q    <= '0;
         pkt_done    <= 1'b0;
         err_crc     <= 1'b0;
         err_len     <= 1'b0;
         err_timeout <= 1'b0;
         err_frame   <= 1'b0;
         err_overrun <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         len_q       <= len_d;
         idx_q       <= idx_d;
         crc_q       <= crc_d;
         to_cnt_q    <= to_cnt_d;
         pkt_done    <= done_d;
         err_crc     <= crc_err_d;
         err_len     <= len_err_d;
         err_timeout <= to_err_d;
         err_frame   <= frm_err_d;
         err_overrun <= ovr_err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      len_d     = len_q;
      idx_d     = idx_q;
      crc_d     = crc_q;
      to_cnt_d  = (to_cnt_q != '0) ? to_cnt_q - TO_W'(1) : '0;
      wr_en     = 1'b0;
      done_d    = 1'b0;
      crc_err_d = 1'b0;
      len_err_d = 1'b0;
      to_err_d  = 1'b0;
      frm_err_d = frame_err;
      ovr_err_d = 1'b0;

      // Mid-frame: every byte restarts the gap timer; a framing error or an
      // expired gap abandons the frame. A byte arriving in the timeout cycle wins.
      if (state_q inside {ADDR, LEN, DATA, CRC}) begin
         if (byte_valid) begin
            to_cnt_d = TO_LOAD;
         end else if (frame_err) begin
            state_d = IDLE;
         end else if (to_cnt_q == '0) begin
            to_err_d = 1'b1;
            state_d  = IDLE;
         end
      end

      case (state_q)
         IDLE: begin
            if (byte_valid && rx_byte == PREFIX) begin
               crc_d    = '0;
               to_cnt_d = TO_LOAD;
               state_d  = ADDR;
            end
         end
         ADDR: begin
            if (byte_valid) begin
               addr_d  = rx_byte[ADDR_W-1:0];
               crc_d   = crc8_next(crc_q, rx_byte);
               state_d = LEN;
            end
         end
         LEN: begin
            if (byte_valid) begin
               crc_d = crc8_next(crc_q, rx_byte);
               len_d = rx_byte;
               idx_d = '0;
               if ({1'b0, rx_byte} > MAX_LEN_V) begin
                  len_err_d = 1'b1;
                  state_d   = IDLE;
               end else if (rx_byte == 8'd0) begin
                  state_d = CRC;
               end else begin
                  state_d = DATA;
               end
            end
         end
         DATA: begin
            if (byte_valid) begin
               wr_en = 1'b1;
               crc_d = crc8_next(crc_q, rx_byte);
               if (idx_inc == len_q) begin
                  idx_d   = '0;
                  state_d = CRC;
               end else begin
                  idx_d = idx_inc;
               end
            end
         end
         CRC: begin
            if (byte_valid) begin
               if (CRC_MODE == 1 && rx_byte != crc_q) begin
                  crc_err_d = 1'b1;
                  state_d   = IDLE;
               end else if (len_q == 8'd0) begin
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  idx_d   = '0;
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            // Bytes arriving now are dropped; a framing error only reports, so a
            // frame already checked good is never lost to line noise.
            if (byte_valid) begin
               ovr_err_d = 1'b1;
            end
            if (m_ready) begin
               if (idx_inc == len_q) begin
                  done_d  = 1'b1;
                  idx_d   = '0;
                  state_d = IDLE;
               end else begin
                  idx_d = idx_inc;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign m_valid = (state_q == DRAIN);
   assign m_data  = m_valid ? mem[idx_q[AW-1:0]] : 8'h00;
   assign m_first = m_valid && (idx_q == 8'd0);
   assign m_last  = m_valid && (idx_inc == len_q);
   assign m_addr  = addr_q;

endmodule
